// File: rtl/if_stage_if.sv
// Handshake/bus bundle between the fetch stage and its neighbours:
// hazard/redirect controls, instruction memory port and the IF/ID outputs.
interface if_stage_if;
   logic        i_stall;
   logic        i_flush;
   logic        i_redirect;
   logic [31:0] i_redirect_target;
   logic        i_trap_taken;
   logic [31:0] i_trap_target;
   logic [31:0] o_imem_adr;
   logic [31:0] i_imem_instr;
   logic [31:0] o_id_instr;
   logic [31:0] o_id_pc;
   logic [31:0] o_id_pc_plus4;
   logic        o_id_valid;
   logic        o_id_misalign;

   modport master (
      input  i_stall, i_flush, i_redirect, i_redirect_target,
      input  i_trap_taken, i_trap_target, i_imem_instr,
      output o_imem_adr, o_id_instr, o_id_pc, o_id_pc_plus4,
      output o_id_valid, o_id_misalign
   );

   modport slave (
      output i_stall, i_flush, i_redirect, i_redirect_target,
      output i_trap_taken, i_trap_target, i_imem_instr,
      input  o_imem_adr, o_id_instr, o_id_pc, o_id_pc_plus4,
      input  o_id_valid, o_id_misalign
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem address and IF/ID register.
// IF_MISALIGN_TRAP_EN adds misaligned-PC detection and the RUN/MIS_WAIT FSM.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic      i_clk,
   input logic      i_rst,
   if_stage_if.master bus
);
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] trap_tgt;
   logic [31:0] redir_tgt;
   logic        redir;
   logic        mis_det;
   logic        mis_wait;
   logic        kill;

   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_valid;

   assign pc_plus4       = pc + 32'd4;
   assign bus.o_imem_adr = pc;

`ifdef IF_MISALIGN_TRAP_EN
   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MIS_WAIT = 1'b1;

   logic [0:0] state;
   logic       id_mis;

   assign trap_tgt  = bus.i_trap_target;
   assign redir_tgt = bus.i_redirect_target;
   assign mis_wait  = (state == MIS_WAIT);
   // The pending exception is older than any EX redirect.
   assign redir     = bus.i_redirect && !mis_wait;
   assign mis_det   = !mis_wait && (pc[1:0] != 2'b00) && !bus.i_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= RUN;
         id_mis <= 1'b0;
      end else begin
         if (bus.i_trap_taken || redir)
            state <= RUN;
         else if (mis_det && !bus.i_flush)
            state <= MIS_WAIT;

         if (kill)
            id_mis <= 1'b0;
         else if (!bus.i_stall)
            id_mis <= mis_det;
      end
   end

   assign bus.o_id_misalign = id_mis;
`else
   assign trap_tgt  = bus.i_trap_target & ~32'h3;
   assign redir_tgt = bus.i_redirect_target & ~32'h3;
   assign redir     = bus.i_redirect;
   assign mis_det   = 1'b0;
   assign mis_wait  = 1'b0;

   assign bus.o_id_misalign = 1'b0;
`endif

   assign kill = bus.i_flush || bus.i_trap_taken || redir;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         pc <= RESET_PC;
      else if (bus.i_trap_taken)
         pc <= trap_tgt;
      else if (redir)
         pc <= redir_tgt;
      else if (!(bus.i_stall || mis_wait || mis_det))
         pc <= pc_plus4;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || kill) begin
         id_instr <= NOP_INSTR;
         id_pc    <= 32'd0;
         id_pc4   <= 32'd0;
         id_valid <= 1'b0;
      end else if (bus.i_stall) begin
         id_instr <= id_instr;
      end else if (mis_wait) begin
         id_instr <= NOP_INSTR;
         id_pc    <= 32'd0;
         id_pc4   <= 32'd0;
         id_valid <= 1'b0;
      end else begin
         id_instr <= mis_det ? NOP_INSTR : bus.i_imem_instr;
         id_pc    <= pc;
         id_pc4   <= pc_plus4;
         id_valid <= 1'b1;
      end
   end

   assign bus.o_id_instr    = id_instr;
   assign bus.o_id_pc       = id_pc;
   assign bus.o_id_pc_plus4 = id_pc4;
   assign bus.o_id_valid    = id_valid;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; imem returns address ^ KEY.
// Covers the default build and, when defined, IF_MISALIGN_TRAP_EN.
module tb_if_stage;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total = 0;

   if_stage_if bus ();

   if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   assign bus.i_imem_instr = bus.o_imem_adr ^ KEY;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_stall = 0;
      bus.i_flush = 0;
      bus.i_redirect = 0;
      bus.i_redirect_target = 0;
      bus.i_trap_taken = 0;
      bus.i_trap_target = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      step();
      chk("rst_adr", bus.o_imem_adr, 32'h0);
      chk("rst_valid", {31'd0, bus.o_id_valid}, 32'd0);
      chk("rst_instr", bus.o_id_instr, NOP);
      chk("rst_pc", bus.o_id_pc, 32'h0);
      chk("rst_pc4", bus.o_id_pc_plus4, 32'h0);
      chk("rst_mis", {31'd0, bus.o_id_misalign}, 32'd0);
      rst = 0;

      for (int i = 1; i <= 4; i++) begin
         step();
         chk("run_adr", bus.o_imem_adr, 32'(4 * i));
         chk("run_pc", bus.o_id_pc, 32'(4 * (i - 1)));
         chk("run_instr", bus.o_id_instr, 32'(4 * (i - 1)) ^ KEY);
         chk("run_valid", {31'd0, bus.o_id_valid}, 32'd1);
      end

      bus.i_stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_adr", bus.o_imem_adr, 32'h10);
         chk("stall_pc", bus.o_id_pc, 32'h0C);
      end
      bus.i_stall = 0;
      step();
      chk("rel_adr", bus.o_imem_adr, 32'h14);
      chk("rel_pc", bus.o_id_pc, 32'h10);
      chk("rel_instr", bus.o_id_instr, 32'h10 ^ KEY);
      step();
      chk("rel_pc2", bus.o_id_pc, 32'h14);

      bus.i_redirect = 1;
      bus.i_redirect_target = 32'h100;
      bus.i_trap_taken = 1;
      bus.i_trap_target = 32'h80;
      step();
      idle();
      chk("trap_adr", bus.o_imem_adr, 32'h80);
      chk("trap_bub_v", {31'd0, bus.o_id_valid}, 32'd0);
      chk("trap_bub_i", bus.o_id_instr, NOP);
      step();
      chk("trap_pc", bus.o_id_pc, 32'h80);
      chk("trap_v", {31'd0, bus.o_id_valid}, 32'd1);
      chk("trap_adr2", bus.o_imem_adr, 32'h84);

      bus.i_redirect = 1;
      bus.i_redirect_target = 32'hFFFF_FFFC;
      step();
      idle();
      chk("wrap_adr0", bus.o_imem_adr, 32'hFFFF_FFFC);
      step();
      chk("wrap_adr", bus.o_imem_adr, 32'h0);
      chk("wrap_pc", bus.o_id_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", bus.o_id_pc_plus4, 32'h0);

      bus.i_stall = 1;
      bus.i_flush = 1;
      step();
      idle();
      chk("sf_adr", bus.o_imem_adr, 32'h0);
      chk("sf_valid", {31'd0, bus.o_id_valid}, 32'd0);
      chk("sf_instr", bus.o_id_instr, NOP);

      step();
      step();
      rst = 1;
      bus.i_redirect = 1;
      bus.i_redirect_target = 32'h300;
      step();
      idle();
      rst = 0;
      chk("mrst_adr", bus.o_imem_adr, 32'h0);
      chk("mrst_valid", {31'd0, bus.o_id_valid}, 32'd0);

`ifdef IF_MISALIGN_TRAP_EN
      bus.i_redirect = 1;
      bus.i_redirect_target = 32'h102;
      step();
      idle();
      chk("mis_adr", bus.o_imem_adr, 32'h102);
      chk("mis_bub", {31'd0, bus.o_id_valid}, 32'd0);
      step();
      chk("mis_valid", {31'd0, bus.o_id_valid}, 32'd1);
      chk("mis_flag", {31'd0, bus.o_id_misalign}, 32'd1);
      chk("mis_pc", bus.o_id_pc, 32'h102);
      chk("mis_instr", bus.o_id_instr, NOP);
      chk("mis_hold", bus.o_imem_adr, 32'h102);
      step();
      chk("mw_valid", {31'd0, bus.o_id_valid}, 32'd0);
      chk("mw_adr", bus.o_imem_adr, 32'h102);
      bus.i_redirect = 1;
      bus.i_redirect_target = 32'h200;
      step();
      idle();
      chk("mw_ign_adr", bus.o_imem_adr, 32'h102);
      chk("mw_ign_v", {31'd0, bus.o_id_valid}, 32'd0);
      bus.i_trap_taken = 1;
      bus.i_trap_target = 32'h80;
      step();
      idle();
      chk("mw_trap_adr", bus.o_imem_adr, 32'h80);
      chk("mw_trap_mis", {31'd0, bus.o_id_misalign}, 32'd0);
      step();
      chk("mw_run_pc", bus.o_id_pc, 32'h80);
      chk("mw_run_v", {31'd0, bus.o_id_valid}, 32'd1);
      chk("mw_run_mis", {31'd0, bus.o_id_misalign}, 32'd0);
`else
      bus.i_redirect = 1;
      bus.i_redirect_target = 32'h102;
      step();
      idle();
      chk("al_adr", bus.o_imem_adr, 32'h100);
      step();
      chk("al_pc", bus.o_id_pc, 32'h100);
      chk("al_mis", {31'd0, bus.o_id_misalign}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
